// File: rtl/cmp_pkg.sv
// Shared types and helpers for the pipelined magnitude comparator.
package cmp_pkg;

    // One-hot compare outcome packed as {gt, eq, lt}.
    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT = 3'b100;
    localparam cmp_res_t CMP_EQ = 3'b010;
    localparam cmp_res_t CMP_LT = 3'b001;

    // Saturating increment; callers narrower than 32 bits cast in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
        return (count >= max) ? count : count + 32'd1;
    endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand stream in, one-hot result stream out, both valid/ready.
interface cmp_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             gt;
    logic             eq;
    logic             lt;

    // Source of operands and sink of results.
    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, gt, eq, lt
    );

    // The comparator pipeline itself.
    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, gt, eq, lt
    );
endinterface

// File: rtl/cmp_core.sv
// Combinational WIDTH-bit magnitude compare, signed or unsigned at run time.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output cmp_res_t         res
);

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;

    // Widen by one bit (sign- or zero-extend) so a single signed compare covers both modes.
    always_comb begin
        a_x = {signed_mode & a[WIDTH-1], a};
        b_x = {signed_mode & b[WIDTH-1], b};
        if ($signed(a_x) > $signed(b_x)) begin
            res = CMP_GT;
        end else if (a_x == b_x) begin
            res = CMP_EQ;
        end else begin
            res = CMP_LT;
        end
    end

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator with valid/ready handshakes and saturating outcome counters.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16  // at most 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cmp_pipe_if.slave        bus,
    input  logic             clear,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             s1_sm_q;
    logic             s2_valid_q;
    cmp_res_t         s2_res_q;
    cmp_res_t         core_res;

    logic             s2_load;
    logic             in_ready;
    logic             in_fire;
    logic             out_fire;

    logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] lt_cnt_q, lt_cnt_d;

    // S2 frees up when empty or drained; S1 may take a new pair whenever it empties into S2.
    assign s2_load  = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = s2_valid_q && bus.out_ready;

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a          (s1_a_q),
        .b          (s1_b_q),
        .signed_mode(s1_sm_q),
        .res        (core_res)
    );

    // Stage 1: capture operands on input handshake, otherwise empty out when S2 takes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_sm_q    <= 1'b0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= bus.a;
            s1_b_q     <= bus.b;
            s1_sm_q    <= bus.signed_mode;
        end else if (s2_load) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Stage 2: hold the result stable while stalled, otherwise take whatever S1 offers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_res_q <= core_res;
            end
        end
    end

    // Next counter values: clear beats a coinciding handshake.
    always_comb begin
        gt_cnt_d = gt_cnt_q;
        eq_cnt_d = eq_cnt_q;
        lt_cnt_d = lt_cnt_q;
        if (clear) begin
            gt_cnt_d = '0;
            eq_cnt_d = '0;
            lt_cnt_d = '0;
        end else if (out_fire) begin
            unique case (s2_res_q)
                CMP_GT:  gt_cnt_d = CNT_W'(sat_inc(32'(gt_cnt_q), CNT_MAX));
                CMP_EQ:  eq_cnt_d = CNT_W'(sat_inc(32'(eq_cnt_q), CNT_MAX));
                CMP_LT:  lt_cnt_d = CNT_W'(sat_inc(32'(lt_cnt_q), CNT_MAX));
                default: ;
            endcase
        end
    end

    // Counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_cnt_q <= '0;
            eq_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            gt_cnt_q <= gt_cnt_d;
            eq_cnt_q <= eq_cnt_d;
            lt_cnt_q <= lt_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    // Gate stale S2 data so the flags read all-zero whenever no result is offered.
    assign bus.gt        = s2_valid_q & s2_res_q[2];
    assign bus.eq        = s2_valid_q & s2_res_q[1];
    assign bus.lt        = s2_valid_q & s2_res_q[0];

    assign gt_cnt = gt_cnt_q;
    assign eq_cnt = eq_cnt_q;
    assign lt_cnt = lt_cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: driver pushes model results, monitor pops on output handshake.
module tb_cmp_pipe;
    import cmp_pkg::*;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned CNT_W   = 12;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          HALF    = 1 << (WIDTH - 1);
    localparam int          FULL    = 1 << WIDTH;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt;

    cmp_pipe_if #(.WIDTH(WIDTH)) bus ();

    cmp_pipe #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .clear (clear),
        .gt_cnt(gt_cnt),
        .eq_cnt(eq_cnt),
        .lt_cnt(lt_cnt)
    );

    always #5 clk = ~clk;

    int       total = 0;
    int       bad   = 0;
    int       rmode = 0;          // 0: out_ready=1, 1: out_ready=0, 2: random
    int       m_cnt [3] = '{0, 0, 0};  // model counters: gt, eq, lt
    cmp_res_t exp_q [$];

    // Reference: interpret operands as plain integers, then compare.
    function automatic cmp_res_t ref_cmp(input int unsigned av, input int unsigned bv,
                                         input bit sm);
        int sa, sb;
        sa = int'(av);
        sb = int'(bv);
        if (sm && sa >= HALF) sa = sa - FULL;
        if (sm && sb >= HALF) sb = sb - FULL;
        if (sa > sb) return CMP_GT;
        if (sa == sb) return CMP_EQ;
        return CMP_LT;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one pair; push its model result when the handshake is known to happen.
    task automatic send(input int unsigned av, input int unsigned bv, input bit sm,
                        input int max_wait);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a           = av[WIDTH-1:0];
        bus.b           = bv[WIDTH-1:0];
        bus.signed_mode = sm;
        forever begin
            #1;
            if (bus.in_ready) begin
                exp_q.push_back(ref_cmp(av, bv, sm));
                @(posedge clk);
                break;
            end
            if (n == max_wait) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stuck at 0 expected 1 at %0t", $time);
                bus.in_valid = 1'b0;
                break;
            end
            n++;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_ready_mode(input int m);
        @(negedge clk);
        #2;
        rmode = m;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Consumer back-pressure.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: pop on each consumed result and update model counters.
    initial begin
        cmp_res_t e;
        int idx;
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got %b expected none",
                                 {bus.gt, bus.eq, bus.lt});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 32'({bus.gt, bus.eq, bus.lt}), 32'(e));
                        idx = (e == CMP_GT) ? 0 : (e == CMP_EQ) ? 1 : 2;
                        if (!clear && m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
                    end
                end
                if (clear) m_cnt = '{0, 0, 0};
            end
        end
    end

    // Per-cycle checks: flag gating/one-hot and counters against the model.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.out_valid)
                    check("onehot", 32'($countones({bus.gt, bus.eq, bus.lt})), 32'd1);
                else
                    check("gated", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
                check("gt_cnt", 32'(gt_cnt), 32'(m_cnt[0]));
                check("eq_cnt", 32'(eq_cnt), 32'(m_cnt[1]));
                check("lt_cnt", 32'(lt_cnt), 32'(m_cnt[2]));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          pa [3] = '{5, 3, 9};
        int          pb [3] = '{3, 5, 9};
        logic        lat_ov  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        cmp_res_t    lat_res [6] = '{3'b000, 3'b000, CMP_GT, CMP_LT, CMP_EQ, 3'b000};
        int          sat_exp [5];
        int          snap [3];
        int unsigned ra, rb;

        bus.in_valid    = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        bus.signed_mode = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flags", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
        check("rst_cnts", 32'({gt_cnt, eq_cnt, lt_cnt}), 32'd0);
        #10;
        rst_n = 1'b1;

        // Latency and throughput: back-to-back pairs, results on consecutive cycles.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 3) begin
                bus.in_valid    = 1'b1;
                bus.a           = WIDTH'(pa[k]);
                bus.b           = WIDTH'(pb[k]);
                bus.signed_mode = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (k < 3) begin
                check("lat_in_ready", 32'(bus.in_ready), 32'd1);
                exp_q.push_back(ref_cmp(pa[k], pb[k], 1'b0));
            end
            check("lat_out_valid", 32'(bus.out_valid), 32'(lat_ov[k]));
            check("lat_flags", 32'({bus.gt, bus.eq, bus.lt}), 32'(lat_res[k]));
        end
        drain();

        // Exhaustive over all pairs in both modes.
        pulse_clear();
        for (int m = 0; m < 2; m++)
            for (int ia = 0; ia < FULL; ia++)
                for (int ib = 0; ib < FULL; ib++)
                    send(ia, ib, m[0], 4);
        drain();
        #1;
        check("exh_gt_cnt", 32'(gt_cnt), 32'd240);
        check("exh_eq_cnt", 32'(eq_cnt), 32'd32);
        check("exh_lt_cnt", 32'(lt_cnt), 32'd240);

        // Back-pressure: only two pairs buffer, the held result and counters stay put.
        set_ready_mode(1);
        send(1, 2, 1'b0, 4);
        send(3, 3, 1'b0, 4);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.a           = WIDTH'(7);
        bus.b           = WIDTH'(1);
        bus.signed_mode = 1'b0;
        snap = '{int'(gt_cnt), int'(eq_cnt), int'(lt_cnt)};
        for (int k = 0; k < 4; k++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_held", 32'({bus.gt, bus.eq, bus.lt}), 32'(CMP_LT));
            check("bp_cnts", 32'({gt_cnt, eq_cnt, lt_cnt}),
                  32'({CNT_W'(snap[0]), CNT_W'(snap[1]), CNT_W'(snap[2])}));
            @(negedge clk);
        end
        #2;
        rmode = 0;
        send(7, 1, 1'b0, 4);
        drain();

        // Saturation of the eq counter.
        pulse_clear();
        for (int k = 0; k < CNT_MAX - 2; k++) send(k % FULL, k % FULL, k[0], 4);
        drain();
        #1;
        check("sat_pre", 32'(eq_cnt), 32'(CNT_MAX - 2));
        sat_exp = '{CNT_MAX - 1, CNT_MAX, CNT_MAX, CNT_MAX, CNT_MAX};
        for (int k = 0; k < 5; k++) begin
            send(k, k, 1'b1, 4);
            drain();
            #1;
            check("sat_step", 32'(eq_cnt), 32'(sat_exp[k]));
        end

        // Clear coinciding with a consume: clear wins.
        pulse_clear();
        set_ready_mode(1);
        send(6, 6, 1'b0, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("clr_held", 32'(bus.out_valid), 32'd1);
        set_ready_mode(0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        check("clr_wins", 32'(eq_cnt), 32'd0);
        check("clr_consumed", 32'(bus.out_valid), 32'd0);
        check("clr_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with two pairs in flight.
        send(1, 1, 1'b0, 4);
        drain();
        set_ready_mode(1);
        send(1, 0, 1'b0, 4);
        send(0, 1, 1'b0, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_cnt = '{0, 0, 0};
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_flags", 32'({bus.gt, bus.eq, bus.lt}), 32'd0);
        check("arst_cnts", 32'({gt_cnt, eq_cnt, lt_cnt}), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        set_ready_mode(0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("post_rst_idle", 32'(bus.out_valid), 32'd0);
        end

        // Random traffic with random back-pressure.
        set_ready_mode(2);
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            ra = $urandom_range(0, FULL - 1);
            rb = $urandom_range(0, FULL - 1);
            send(ra, rb, 1'($urandom_range(0, 1)), 1000);
        end
        drain();
        #1;
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
